// File: rtl/bcd_calc_seq_pkg.sv
// Purpose : shared op codes, op FSM encoding and BCD->binary helper for the BCD calculator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package bcd_calc_seq_pkg;

  localparam logic [2:0] OP_DISP = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_DIVRUN = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Up to four packed BCD digits, most significant digit in [15:12].
  // Callers with fewer digits zero-extend; 9999 fits in 14 bits.
  function automatic logic [13:0] bcd2bin(input logic [15:0] bcd);
    int acc;
    acc = 0;
    for (int i = 3; i >= 0; i--) begin
      acc = acc * 10 + int'(bcd[4*i +: 4]);
    end
    return 14'(acc);
  endfunction

endpackage

// File: rtl/bcd_calc_seq_if.sv
// Purpose : op request / result bundle between the calculator and its controller.
// Latency : n/a (wires only).
// Backpressure: op_valid is taken only when op_ready is high; nothing is queued.
// Ports   : op_valid, op_code (master->slave); op_ready, busy, done, result, dot, err (slave->master).
interface bcd_calc_seq_if #(
  parameter int DIGITS = 2
);
  localparam int RES_W = $clog2(10**(2*DIGITS)) + 1;

  logic             op_valid;
  logic [2:0]       op_code;
  logic             op_ready;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;
  logic             dot;
  logic             err;

  modport master (
    output op_valid, op_code,
    input  op_ready, busy, done, result, dot, err
  );

  modport slave (
    input  op_valid, op_code,
    output op_ready, busy, done, result, dot, err
  );
endinterface

// File: rtl/bcd_calc_seq_divider.sv
// Purpose : W-bit restoring shift-subtract divider, one quotient bit per cycle.
// Latency : start at edge S; done pulses in the W-th cycle after S with quot/rem/dz valid.
// Backpressure: none; a start while busy restarts the division.
// Ports   : clk, rst_n, start, dividend, divisor -> busy, done, quot, rem, dz.
module bcd_calc_seq_divider #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         dz
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  quot_q;   // dividend bits shift out the top, quotient bits shift in
  logic [W-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          dz_q;

  logic [W:0]   shifted;
  logic         fits;
  logic [W-1:0] diff;

  always_comb begin
    shifted = {rem_q, quot_q[W-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    // When fits, the true difference is below the divisor, so W bits hold it exactly.
    diff    = shifted[W-1:0] - dvs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= '0;
        quot_q <= dividend;
        dvs_q  <= divisor;
        cnt_q  <= CW'(W);
        busy_q <= 1'b1;
        dz_q   <= (divisor == '0);
      end else if (busy_q) begin
        rem_q  <= fits ? diff : shifted[W-1:0];
        quot_q <= {quot_q[W-2:0], fits};
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign dz   = dz_q;

endmodule

// File: rtl/bcd_calc_seq.sv
// Purpose : clocked BCD calculator: button-driven digit entry, single-cycle ops and a serial divider.
// Latency : done 2 cycles after accept for single-cycle ops, OP_W+2 for DIV/MOD.
// Backpressure: op_ready only in IDLE; requests arriving while busy are dropped, not queued.
// Ports   : clk, rst_n, inc[2*DIGITS] (async buttons), bus (slave op/result bundle), digits_o {A,B}.
module bcd_calc_seq #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*DIGITS-1:0]   inc,
  bcd_calc_seq_if.slave         bus,
  output logic [8*DIGITS-1:0]   digits_o
);
  import bcd_calc_seq_pkg::*;

  localparam int NDIG  = 2 * DIGITS;
  localparam int OP_W  = $clog2(10**DIGITS);
  localparam int RES_W = $clog2(10**(2*DIGITS)) + 1;
  localparam int MAG_W = RES_W - 1;
  localparam logic [MAG_W-1:0] SCALE = MAG_W'(10**DIGITS);

  // ---------------- button synchroniser and rising-edge detect ----------------
  logic [NDIG-1:0] inc_s1, inc_s2, inc_s3;
  logic [NDIG-1:0] inc_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_s1 <= '0;
      inc_s2 <= '0;
      inc_s3 <= '0;
    end else begin
      inc_s1 <= inc;
      inc_s2 <= inc_s1;
      inc_s3 <= inc_s2;
    end
  end

  assign inc_rise = inc_s2 & ~inc_s3;

  // ---------------- FSM state and latched operands ----------------
  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [OP_W-1:0]  a_q, b_q;
  logic [RES_W-1:0] res_q, res_d;
  logic             dot_q, dot_d;
  logic             err_q, err_d;
  logic             accept, is_div_op, div_start;
  logic             op_ready, busy, done;

  // ---------------- digit counters ----------------
  logic [8*DIGITS-1:0] dig_q;
  logic                clr_now;

  // CLR writes the digits on the EXEC edge and overrides any press landing on that edge.
  assign clr_now = (state_q == S_EXEC) && (op_q == OP_CLR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
    end else if (clr_now) begin
      dig_q <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (inc_rise[i]) begin
          dig_q[4*i +: 4] <= (dig_q[4*i +: 4] == 4'd9) ? 4'd0 : dig_q[4*i +: 4] + 4'd1;
        end
      end
    end
  end

  assign digits_o = dig_q;

  // ---------------- live operands ----------------
  logic [OP_W-1:0] a_bin, b_bin;
  assign a_bin = OP_W'(bcd2bin(16'(dig_q[8*DIGITS-1:4*DIGITS])));
  assign b_bin = OP_W'(bcd2bin(16'(dig_q[4*DIGITS-1:0])));

  // ---------------- divider ----------------
  logic            div_busy, div_done, div_dz;
  logic [OP_W-1:0] div_quot, div_rem;

  assign is_div_op = (bus.op_code == OP_DIV) || (bus.op_code == OP_MOD);
  assign div_start = accept && is_div_op;

  // The divider captures the live operands on the accept edge, the same edge that
  // latches a_q/b_q, so both views of the operands are identical.
  bcd_calc_seq_divider #(.W(OP_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a_bin),
    .divisor  (b_bin),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem),
    .dz       (div_dz)
  );

  // ---------------- single-cycle datapath ----------------
  logic [MAG_W-1:0] a_x, b_x, mag_disp, mag_add, mag_mul, mag_amb, mag_bma;

  always_comb begin
    a_x      = MAG_W'(a_q);
    b_x      = MAG_W'(b_q);
    mag_disp = a_x * SCALE + b_x;
    mag_add  = a_x + b_x;
    mag_mul  = a_x * b_x;
    mag_amb  = a_x - b_x;
    mag_bma  = b_x - a_x;
  end

  // ---------------- op FSM: next state and result update ----------------
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    res_d    = res_q;
    dot_d    = dot_q;
    err_d    = err_q;
    op_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (bus.op_valid) begin
          accept  = 1'b1;
          state_d = is_div_op ? S_DIVRUN : S_EXEC;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_DONE;
        case (op_q)
          OP_DISP: begin res_d = {1'b0, mag_disp}; dot_d = 1'b0; err_d = 1'b0; end
          OP_ADD:  begin res_d = {1'b0, mag_add};  dot_d = 1'b1; err_d = 1'b0; end
          OP_SUB:  begin
            res_d = (a_q >= b_q) ? {1'b0, mag_amb} : {1'b1, mag_bma};
            dot_d = 1'b1;
            err_d = 1'b0;
          end
          OP_MUL:  begin res_d = {1'b0, mag_mul};  dot_d = 1'b1; err_d = 1'b0; end
          OP_CLR:  begin res_d = '0;               dot_d = 1'b0; err_d = 1'b0; end
          default: ; // reserved code: completes with outputs untouched
        endcase
      end
      S_DIVRUN: begin
        busy = 1'b1;
        // done and busy are exclusive in the divider; both are required to finish.
        if (div_done && !div_busy) begin
          state_d = S_DONE;
          dot_d   = 1'b1;
          err_d   = div_dz;
          if (div_dz) begin
            res_d = '0;
          end else begin
            res_d = {1'b0, MAG_W'((op_q == OP_MOD) ? div_rem : div_quot)};
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_DISP;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      dot_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      dot_q   <= dot_d;
      err_q   <= err_d;
      if (accept) begin
        op_q <= bus.op_code;
        a_q  <= a_bin;
        b_q  <= b_bin;
      end
    end
  end

  assign bus.op_ready = op_ready;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.result   = res_q;
  assign bus.dot      = dot_q;
  assign bus.err      = err_q;

endmodule
